// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage access unit.
package mem_access_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned REG_W           = 5;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Halfword lane select from address bit 1.
    function automatic logic [3:0] sh_be(input logic addr_bit1);
        return addr_bit1 ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register bank; a bubble kills the write-enable and syscall bits.
module mem_wb_reg
    import mem_access_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_bubble,
    input  logic [XLEN-1:0]  i_data,
    input  logic [REG_W-1:0] i_rw,
    input  logic             i_regwrite,
    input  logic             i_syscall,
    output logic [XLEN-1:0]  o_data,
    output logic [REG_W-1:0] o_rw,
    output logic             o_regwrite,
    output logic             o_syscall
);

    logic [XLEN-1:0]  r_data;
    logic [REG_W-1:0] r_rw;
    logic             r_regwrite;
    logic             r_syscall;

    // Data and destination hold across bubbles; only the side-effect bits are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_rw       <= '0;
            r_regwrite <= 1'b0;
            r_syscall  <= 1'b0;
        end else if (i_bubble) begin
            r_regwrite <= 1'b0;
            r_syscall  <= 1'b0;
        end else if (i_en) begin
            r_data     <= i_data;
            r_rw       <= i_rw;
            r_regwrite <= i_regwrite;
            r_syscall  <= i_syscall;
        end
    end

    assign o_data     = r_data;
    assign o_rw       = r_rw;
    assign o_regwrite = r_regwrite;
    assign o_syscall  = r_syscall;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: runs loads / word stores / halfword stores against a handshaked
// variable-latency data memory, stalls upstream, and registers MEM/WB results.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] M_R,
    input  logic [31:0] M_R2,
    input  logic [31:0] M_pc_4,
    input  logic [4:0]  M_RW,
    input  logic        M_jal,
    input  logic        M_MemtoReg,
    input  logic        M_MemWrite,
    input  logic        M_sh,
    input  logic        M_RegWrite,
    input  logic        M_syscall,
    input  logic        M_mfc0,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic [31:0] W_data,
    output logic [4:0]  W_RW,
    output logic        W_RegWrite,
    output logic        W_syscall,
    input  logic        err_clr,
    output logic        err_align,
    output logic        err_timeout
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_abort;
    logic             r_dm_req;
    logic             r_dm_we;
    logic [31:0]      r_dm_addr;
    logic [3:0]       r_dm_be;
    logic [31:0]      r_dm_wdata;
    logic             r_err_align;
    logic             r_err_timeout;

    logic             w_access;
    logic             w_misaligned;
    logic             w_start;
    logic             w_timeout;
    logic             w_align_evt;
    logic [31:0]      w_wb_data;
    logic             w_wb_regwrite;
    logic             w_unused;

    // mfc0 values already arrive on M_R, so the flag itself is not needed here.
    assign w_unused = M_mfc0;

    assign w_access     = M_MemtoReg | M_MemWrite;
    assign w_misaligned = w_access & (M_sh ? M_R[0] : (M_R[1:0] != 2'b00));
    assign w_start      = (r_state == IDLE) & w_access & ~w_misaligned;
    assign w_timeout    = (r_state == BUSY) & ~dm_ack & (r_cnt == LP_CNT_LAST);
    assign w_align_evt  = (r_state == IDLE) & w_misaligned;

    // Stall rises in the detect cycle, before the state register has moved.
    assign mem_stall = w_start | (r_state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_abort    <= 1'b0;
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_be    <= '0;
            r_dm_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state    <= BUSY;
                        r_cnt      <= '0;
                        r_abort    <= 1'b0;
                        r_dm_req   <= 1'b1;
                        r_dm_we    <= M_MemWrite;
                        r_dm_addr  <= {M_R[31:2], 2'b00};
                        r_dm_be    <= M_sh ? sh_be(M_R[1]) : BE_WORD;
                        r_dm_wdata <= M_sh ? {M_R2[15:0], M_R2[15:0]} : M_R2;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (dm_ack) begin
                        r_rdata  <= dm_rdata;
                        r_dm_req <= 1'b0;
                        r_state  <= DONE;
                    end else if (w_timeout) begin
                        r_rdata  <= '0;
                        r_abort  <= 1'b1;
                        r_dm_req <= 1'b0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    // Abort only qualifies the writeback taken on this edge.
                    r_abort <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state  <= IDLE;
                    r_dm_req <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a set event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_align   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_align_evt)
                r_err_align <= 1'b1;
            else if (err_clr)
                r_err_align <= 1'b0;
            if (w_timeout)
                r_err_timeout <= 1'b1;
            else if (err_clr)
                r_err_timeout <= 1'b0;
        end
    end

    assign w_wb_data     = M_jal ? M_pc_4 : (M_MemtoReg ? r_rdata : M_R);
    assign w_wb_regwrite = M_RegWrite & ~r_abort & ~w_misaligned;

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (~mem_stall),
        .i_bubble   (mem_stall),
        .i_data     (w_wb_data),
        .i_rw       (M_RW),
        .i_regwrite (w_wb_regwrite),
        .i_syscall  (M_syscall),
        .o_data     (W_data),
        .o_rw       (W_RW),
        .o_regwrite (W_RegWrite),
        .o_syscall  (W_syscall)
    );

    assign dm_req      = r_dm_req;
    assign dm_we       = r_dm_we;
    assign dm_addr     = r_dm_addr;
    assign dm_be       = r_dm_be;
    assign dm_wdata    = r_dm_wdata;
    assign err_align   = r_err_align;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against an instruction-level model.
module tb_mem_access_unit;

    localparam int T = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] M_R, M_R2, M_pc_4;
    logic [4:0]  M_RW;
    logic        M_jal, M_MemtoReg, M_MemWrite, M_sh, M_RegWrite, M_syscall, M_mfc0;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic        mem_stall;
    logic [31:0] W_data;
    logic [4:0]  W_RW;
    logic        W_RegWrite, W_syscall;
    logic        err_clr, err_align, err_timeout;

    int          n_cmp;
    int          n_fail;
    logic [31:0] m_rdq;
    logic        m_ea;
    logic        m_et;

    mem_access_unit #(.TIMEOUT(T), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .M_R(M_R), .M_R2(M_R2), .M_pc_4(M_pc_4), .M_RW(M_RW),
        .M_jal(M_jal), .M_MemtoReg(M_MemtoReg), .M_MemWrite(M_MemWrite), .M_sh(M_sh),
        .M_RegWrite(M_RegWrite), .M_syscall(M_syscall), .M_mfc0(M_mfc0),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_stall(mem_stall),
        .W_data(W_data), .W_RW(W_RW), .W_RegWrite(W_RegWrite), .W_syscall(W_syscall),
        .err_clr(err_clr), .err_align(err_align), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic set_nop();
        M_R = 32'h0; M_R2 = 32'h0; M_pc_4 = 32'h0; M_RW = 5'd0;
        M_jal = 1'b0; M_MemtoReg = 1'b0; M_MemWrite = 1'b0; M_sh = 1'b0;
        M_RegWrite = 1'b0; M_syscall = 1'b0; M_mfc0 = 1'b0;
    endtask

    // kind: 0 alu, 1 lw, 2 sw, 3 sh, 4 jal, 5 mfc0. d = BUSY cycles before ack (d >= T never acks).
    // Called at a falling edge; returns at the falling edge after the instruction retires.
    task automatic run_instr(input int kind, input logic [31:0] r, input logic [31:0] r2,
                             input logic [31:0] pc4, input logic [4:0] rw, input logic regw,
                             input logic sys, input int d, input logic [31:0] rdata,
                             input logic clr);
        logic        mtr, mw, sh, acc, mis, go, tmo, was_stall;
        logic [3:0]  be_exp;
        logic [31:0] wd_exp, wb_exp;
        int          busy, stall_n, req_n, cyc;
        mtr    = (kind == 1);
        mw     = (kind == 2) || (kind == 3);
        sh     = (kind == 3);
        acc    = mtr | mw;
        mis    = acc && (sh ? r[0] : (r[1:0] != 2'b00));
        go     = acc && !mis;
        tmo    = go && (d >= T);
        busy   = !go ? 0 : ((d < T) ? d + 1 : T);
        be_exp = !sh ? 4'hF : (r[1] ? 4'hC : 4'h3);
        wd_exp = sh ? {r2[15:0], r2[15:0]} : r2;

        M_R = r; M_R2 = r2; M_pc_4 = pc4; M_RW = rw;
        M_jal = (kind == 4); M_mfc0 = (kind == 5);
        M_MemtoReg = mtr; M_MemWrite = mw; M_sh = sh;
        M_RegWrite = regw; M_syscall = sys;
        err_clr = clr;
        dm_ack = 1'b0;
        stall_n = 0; req_n = 0; cyc = 0;

        forever begin
            #1;
            was_stall = mem_stall;
            if (cyc > 0 && was_stall) begin
                check("bubble_regwrite", 32'(W_RegWrite), 32'h0);
                check("bubble_syscall", 32'(W_syscall), 32'h0);
            end
            if (dm_req) begin
                check("dm_addr", dm_addr, {r[31:2], 2'b00});
                check("dm_be", 32'(dm_be), 32'(be_exp));
                check("dm_we", 32'(dm_we), 32'(mw));
                if (mw) check("dm_wdata", dm_wdata, wd_exp);
                dm_ack   = (req_n == d);
                dm_rdata = dm_ack ? rdata : $urandom;
                req_n++;
            end else begin
                dm_ack   = 1'($urandom_range(0, 1));
                dm_rdata = $urandom;
            end
            if (was_stall) stall_n++;
            @(negedge clk);
            err_clr = 1'b0;
            cyc++;
            if (!was_stall) break;
            if (cyc > T + 8) begin
                check("cycle_budget", 32'(cyc), 32'(T + 8));
                break;
            end
        end
        dm_ack = 1'b0;

        if (go) m_rdq = tmo ? 32'h0 : rdata;
        wb_exp = (kind == 4) ? pc4 : (mtr ? m_rdq : r);
        m_ea   = clr ? mis : (m_ea | mis);
        m_et   = clr ? tmo : (m_et | tmo);

        check("stall_cycles", 32'(stall_n), 32'(go ? busy + 1 : 0));
        check("req_cycles", 32'(req_n), 32'(busy));
        check("W_data", W_data, wb_exp);
        check("W_RW", 32'(W_RW), 32'(rw));
        check("W_RegWrite", 32'(W_RegWrite), 32'(regw & !tmo & !mis));
        check("W_syscall", 32'(W_syscall), 32'(sys));
        check("err_align", 32'(err_align), 32'(m_ea));
        check("err_timeout", 32'(err_timeout), 32'(m_et));
    endtask

    initial begin
        int          k;
        logic [31:0] r;
        n_cmp = 0; n_fail = 0;
        m_rdq = 32'h0; m_ea = 1'b0; m_et = 1'b0;
        rst_n = 1'b0; err_clr = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
        set_nop();

        #12;
        check("rst_dm_req", 32'(dm_req), 32'h0);
        check("rst_W_data", W_data, 32'h0);
        check("rst_W_RW", 32'(W_RW), 32'h0);
        check("rst_W_RegWrite", 32'(W_RegWrite), 32'h0);
        check("rst_err_align", 32'(err_align), 32'h0);
        check("rst_err_timeout", 32'(err_timeout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(0, 32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        run_instr(1, 32'h100, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 1, 32'hDEADBEEF, 1'b0);
        run_instr(3, 32'h202, 32'h5555ABCD, 32'h0, 5'd0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
        run_instr(3, 32'h200, 32'h0000F00D, 32'h0, 5'd0, 1'b0, 1'b0, 2, 32'h0, 1'b0);
        run_instr(2, 32'h103, 32'h11112222, 32'h0, 5'd3, 1'b0, 1'b0, 0, 32'h0, 1'b0);
        run_instr(0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 0, 32'h0, 1'b1);
        run_instr(1, 32'h104, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 10, 32'hCAFEF00D, 1'b0);
        run_instr(4, 32'h0, 32'h0, 32'h0040_0008, 5'd31, 1'b1, 1'b1, 0, 32'h0, 1'b0);
        run_instr(1, 32'h102, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 0, 32'h0, 1'b0);

        // Reset in the middle of a BUSY access, followed by a stray ack.
        M_R = 32'h40; M_MemtoReg = 1'b1; M_MemWrite = 1'b0; M_sh = 1'b0;
        M_jal = 1'b0; M_RegWrite = 1'b1; M_RW = 5'd7; dm_ack = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_req", 32'(dm_req), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dm_req", 32'(dm_req), 32'h0);
        check("mid_rst_W_data", W_data, 32'h0);
        check("mid_rst_W_RW", 32'(W_RW), 32'h0);
        check("mid_rst_W_RegWrite", 32'(W_RegWrite), 32'h0);
        check("mid_rst_W_syscall", 32'(W_syscall), 32'h0);
        check("mid_rst_err_align", 32'(err_align), 32'h0);
        check("mid_rst_err_timeout", 32'(err_timeout), 32'h0);
        set_nop();
        dm_ack = 1'b1; dm_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("stray_ack_req", 32'(dm_req), 32'h0);
        check("stray_ack_stall", 32'(mem_stall), 32'h0);
        dm_ack = 1'b0;
        m_rdq = 32'h0; m_ea = 1'b0; m_et = 1'b0;
        @(negedge clk);
        run_instr(1, 32'h41, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 0, 32'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            k = int'($urandom_range(0, 5));
            r = $urandom;
            if ($urandom_range(0, 2) != 0) r[1:0] = 2'b00;
            run_instr(k, r, $urandom, $urandom, 5'($urandom),
                      ((k == 2) || (k == 3)) ? 1'b0 : 1'($urandom),
                      1'($urandom), int'($urandom_range(0, 5)), $urandom,
                      ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
